// File: rtl/thread_pc_sequencer.sv
// Round-robin per-thread PC sequencer: one fixed issue slot per thread per rotation,
// with retire feedback (increment / jump / annulled re-issue), host PC loads and a stall counter.
module thread_pc_sequencer #(
    parameter int PC_WIDTH          = 10,
    parameter int THREAD_COUNT      = 8,
    parameter int THREAD_ADDR_WIDTH = 3,
    parameter int PC_RESET_BASE     = 0,
    parameter int PC_RESET_STRIDE   = 0,
    parameter int STALL_COUNT_WIDTH = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [THREAD_COUNT-1:0]      thread_enable,
    input  logic                         retire_valid,
    input  logic [THREAD_ADDR_WIDTH-1:0] retire_thread,
    input  logic [PC_WIDTH-1:0]          retire_pc,
    input  logic                         retire_io_ready,
    input  logic                         retire_jump,
    input  logic [PC_WIDTH-1:0]          retire_target,
    input  logic                         host_wren,
    input  logic [THREAD_ADDR_WIDTH-1:0] host_thread,
    input  logic [PC_WIDTH-1:0]          host_pc,
    output logic                         issue_valid,
    output logic [THREAD_ADDR_WIDTH-1:0] issue_thread,
    output logic [PC_WIDTH-1:0]          issue_pc,
    output logic [STALL_COUNT_WIDTH-1:0] stall_events
);

    logic [THREAD_ADDR_WIDTH-1:0] slot;
    logic [PC_WIDTH-1:0]          pc      [THREAD_COUNT];
    logic [PC_WIDTH-1:0]          pc_next [THREAD_COUNT];

    // Ids at or above THREAD_COUNT never match any t, so they fall through to "hold".
    always_comb begin
        for (int t = 0; t < THREAD_COUNT; t++) begin
            pc_next[t] = pc[t];
            if (host_wren && host_thread == THREAD_ADDR_WIDTH'(t)) begin
                pc_next[t] = host_pc;
            end else if (retire_valid && retire_thread == THREAD_ADDR_WIDTH'(t)) begin
                if (!retire_io_ready) begin
                    pc_next[t] = retire_pc;
                end else if (retire_jump) begin
                    pc_next[t] = retire_target;
                end else begin
                    pc_next[t] = retire_pc + PC_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot         <= '0;
            issue_valid  <= 1'b0;
            issue_thread <= '0;
            issue_pc     <= '0;
            stall_events <= '0;
            for (int t = 0; t < THREAD_COUNT; t++) begin
                pc[t] <= PC_WIDTH'(PC_RESET_BASE + t * PC_RESET_STRIDE);
            end
        end else begin
            slot <= (slot == THREAD_ADDR_WIDTH'(THREAD_COUNT - 1)) ? '0
                                                                   : slot + THREAD_ADDR_WIDTH'(1);
            // Issue from the post-update value so a same-cycle write is never fetched stale.
            issue_thread <= slot;
            issue_pc     <= pc_next[slot];
            issue_valid  <= thread_enable[slot];
            for (int t = 0; t < THREAD_COUNT; t++) begin
                pc[t] <= pc_next[t];
            end
            if (retire_valid && !retire_io_ready &&
                stall_events != {STALL_COUNT_WIDTH{1'b1}}) begin
                stall_events <= stall_events + STALL_COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/thread_pc_sequencer.md
Name: thread_pc_sequencer

Overview:
Parametrised per-thread program-counter sequencer for the next-generation Octavo control path. It replaces the fixed PC memory loop with a round-robin issue slot over THREAD_COUNT threads and a retire feedback port. The retire port applies increment, jump or I/O-stall re-issue. It adds a per-thread enable mask, host PC loading and a saturating stall-event counter. It feeds issue_pc to the instruction memory read address.

Parameters:
PC_WIDTH, 10, width of each thread PC and instruction address
THREAD_COUNT, 8, number of hardware threads (any value >= 2; need not be a power of two)
THREAD_ADDR_WIDTH, 3, width of thread id fields; 2^THREAD_ADDR_WIDTH >= THREAD_COUNT
PC_RESET_BASE, 0, reset PC of thread 0
PC_RESET_STRIDE, 0, reset PC of thread t = PC_RESET_BASE + t*PC_RESET_STRIDE, truncated to PC_WIDTH
STALL_COUNT_WIDTH, 16, width of stall_events counter

Ports:
clock  in  1  sole clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
thread_enable  in  THREAD_COUNT  bit t=1 lets thread t issue
retire_valid  in  1  retire record present this cycle
retire_thread  in  THREAD_ADDR_WIDTH  thread of retiring instruction
retire_pc  in  PC_WIDTH  PC of retiring instruction
retire_io_ready  in  1  0 = instruction annulled by I/O empty/full, must re-issue
retire_jump  in  1  1 = taken branch/jump
retire_target  in  PC_WIDTH  jump destination
host_wren  in  1  external PC load strobe
host_thread  in  THREAD_ADDR_WIDTH  thread to load
host_pc  in  PC_WIDTH  value to load
issue_valid  out  1  issue_pc/issue_thread carry a live fetch
issue_thread  out  THREAD_ADDR_WIDTH  thread of current fetch
issue_pc  out  PC_WIDTH  fetch address to I memory
stall_events  out  STALL_COUNT_WIDTH  count of annulled retires, saturating

Behaviour:
- Reset (async assert, sync-safe release): slot=0; pc[t]=PC_RESET_BASE+t*PC_RESET_STRIDE; issue_valid=0, issue_thread=0, issue_pc=0, stall_events=0.
- Slot counter: slot advances by 1 every cycle and wraps from THREAD_COUNT-1 to 0. No stall exists; the rotation is fixed.
- Issue (1-cycle latency): at each edge, issue_thread<=slot, issue_pc<=next_pc(slot), issue_valid<=thread_enable[slot]. A disabled thread still occupies its slot, but issue_valid=0.
- Per-thread update for the thread's next value, first match wins:
  1. host_wren with host_thread==t: pc[t]<=host_pc.
  2. retire_valid with retire_thread==t and retire_io_ready=0: pc[t]<=retire_pc.
  3. retire_valid with retire_thread==t and retire_jump=1: pc[t]<=retire_target.
  4. retire_valid with retire_thread==t otherwise: pc[t]<=retire_pc+1, mod 2^PC_WIDTH (2^PC_WIDTH-1 wraps to 0).
  5. Otherwise pc[t] holds.
- Retire applies regardless of thread_enable.
- Bypass: next_pc(slot) is the post-update value above. If the host write or retire targets the thread being issued in the same cycle, the issue carries the new PC, never the stale one.
- Out-of-range ids: a retire_thread or host_thread >= THREAD_COUNT is ignored and changes no state.
- Host write and retire to different threads in the same cycle: both apply.
- stall_events increments on each retire_valid with retire_io_ready=0, including retires ignored as out-of-range. It saturates at all-ones.
- retire_jump is ignored when retire_io_ready=0; an annulled jump is re-issued.
- Reset mid-operation: all state returns to reset values immediately. In-flight retires arriving after release are processed normally.

Test Plan:
- Reset, THREAD_COUNT=8, PC_RESET_STRIDE=16, all enabled, no retires -> issue_thread 0..7 repeating, issue_pc 0,16,32,...,112, issue_valid=1 from the first edge after release.
- Retire thread 3, pc=40, io_ready=1, jump=0 -> next issue of thread 3 shows 41; retire pc=1023 (PC_WIDTH=10) -> 0.
- Retire thread 2, pc=55, io_ready=0, jump=1, target=9 -> thread 2 re-issues 55; stall_events +1.
- host_wren thread 5 pc=200 with simultaneous retire thread 5 pc=7 in thread 5's slot cycle -> issue_pc=200 at next edge, with no stale value.
- THREAD_COUNT=6, thread_enable=6'b101010 -> slots 0..5 wrap; issue_valid pattern 0,1,0,1,0,1; retire_thread=7 ignored.
- STALL_COUNT_WIDTH=4, 20 annulled retires -> stall_events=15 and holds; reset_n pulse mid-stream -> all outputs 0 and PCs back to reset values.
